shot_sequencer: RTL and testbench
=================================

Name: shot_sequencer

Overview:
- Sequential front end of the Battleship scorer. It turns a KEY[0] press plus the switch coordinates into a timed series of square probes to the combinational square checker, and accumulates the per-square replies into one registered shot result.
- It owns the big-bomb inventory, the hit counter and the input-error flag.
- It drives the LEDR/LEDG/HEX-facing logic; the checker is the responder and this block is the initiator.

Parameters:
- BIG_BOMBS, default 2: big bombs available after reset (legal range 0..2).
- HIT_SAT, default 9: saturation value of num_hits, chosen so one BCD digit can show it.

Ports:
- clock  in  1  system clock.
- reset_L  in  1  reset, asynchronous assert, active-low.
- key_L  in  1  raw KEY[0], active-low, asynchronous to clock.
- x_in  in  4  target column, SW[7:4].
- y_in  in  4  target row, SW[3:0].
- big_in  in  1  use big bomb, SW[17].
- probe_x  out  4  square currently presented to the checker.
- probe_y  out  4  row of that square.
- probe_valid  out  1  probe_x/probe_y are on-board and the reply is to be accumulated.
- chk_hit  in  1  checker reply for the probed square, same cycle.
- chk_near  in  1  checker near-miss reply, same cycle.
- chk_ship  in  5  checker one-hot ship code, same cycle.
- hit  out  1  last shot hit.
- near_miss  out  1  last shot near miss.
- miss  out  1  last shot miss.
- biggest_ship_hit  out  5  one-hot code of the largest ship hit by the last shot.
- num_hits  out  4  count of shots that hit.
- big_left  out  2  big bombs remaining.
- something_wrong  out  1  last press rejected.
- busy  out  1  a shot is in progress.
- done  out  1  one-cycle pulse when the shot result registers update.

Behaviour:
- Reset is asynchronous, active-low.
  - hit, near_miss, miss, biggest_ship_hit, num_hits, something_wrong, busy and done all reset to 0.
  - big_left resets to BIG_BOMBS.
  - The FSM resets to IDLE and the key synchroniser resets to 1 (released).
- key_L passes through a 2-flop synchroniser and then a falling-edge detector, producing shot_start.
  - shot_start is a single pulse per press; holding the key down does not retrigger.
- FSM states: IDLE, VALIDATE, PROBE, FINISH.
- IDLE:
  - On shot_start (cycle k), latch x_in, y_in, big_in and go to VALIDATE.
  - shot_start in any other state is ignored.
- VALIDATE (k+1): the press is wrong if any of these holds:
  - latched X is outside 1..10;
  - latched Y is outside 1..10;
  - big is set and big_left==0.
- VALIDATE outcome:
  - If wrong: set something_wrong=1 at k+2, leave the other result registers unchanged, return to IDLE, no done pulse.
  - Otherwise: clear something_wrong, clear the accumulators, step=0, go to PROBE.
- PROBE: one step per cycle.
  - A small bomb has 1 step.
  - A big bomb has 5 steps, in the order centre, (X,Y-1), (X,Y+1), (X-1,Y), (X+1,Y).
  - A step whose square leaves 1..10 still takes its cycle, with probe_valid=0 and the reply ignored.
  - probe_x/probe_y/probe_valid are combinational from the latched centre and step; they are 0/0/0 outside PROBE.
  - The accumulator updates at each clock edge while probe_valid=1: acc_hit |= chk_hit, acc_near |= chk_near, acc_ship |= chk_ship.
- FINISH (one cycle): registered outputs update at the end of FINISH, and done=1 for the following cycle.
  - hit = acc_hit.
  - near_miss = !acc_hit & acc_near.
  - miss = !acc_hit & !acc_near.
  - biggest_ship_hit = highest set bit of acc_ship (one-hot), or 0 if none.
  - num_hits increments if acc_hit, saturating at HIT_SAT.
  - big_left decrements if big.
- Latency from shot_start to done:
  - small shot: k+4;
  - big shot: k+8.
- busy=1 in VALIDATE, PROBE and FINISH.
- Arithmetic: the neighbour computation uses 5-bit intermediates so that 0-1 and 10+1 are detected as off-board, with no wrap.

Optional Feature:
- Macro: SHOT_SEQ_REPEAT_CHECK_EN.
- When defined:
  - A 100-bit fired-centre map is cleared on reset.
  - VALIDATE additionally flags wrong if the centre square was already fired at.
  - The map bit is set in FINISH.
- When undefined: no map exists and repeats are legal.

Decomposition:
- battleship_pkg holds:
  - the state enum;
  - BOARD_MIN=1 and BOARD_MAX=10;
  - the ship one-hot constants (PATROL 00001, 00010, 00100, 01000, CARRIER 10000);
  - the big-bomb step offset table.
- One sub-module: key_edge_detect (synchroniser plus falling-edge pulse).

Test Plan:
- Small shot at (7,6) -> hit=1, biggest_ship_hit=00001, num_hits=1, done at k+4, big_left=2.
- Small shot at (7,5), where the checker reports near -> near_miss=1, hit=0, miss=0. Small shot at (6,8) -> miss=1.
- Big shot at (3,2) -> probes (3,2),(3,1),(3,3),(2,2),(4,2) on consecutive cycles; biggest_ship_hit=10000; big_left 2->1; num_hits +1; done at k+8.
- Big shot at (1,1) -> steps 1 and 3 have probe_valid=0 and stray chk_hit in those cycles is ignored; the result is taken from (1,1),(1,2),(2,1) only.
- X=0, X=11, or a big shot with big_left=0 -> something_wrong=1 at k+2; hit/near_miss/miss/big_left unchanged; no done. Next valid press clears something_wrong.
- Key held low 20 cycles -> exactly one shot. reset_L low during PROBE -> all outputs at reset values immediately and FSM in IDLE. num_hits saturates at 9 after 10 hits.

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared types and constants for the Battleship scorer: FSM states, board limits,
// ship one-hot codes and the big-bomb probe offset table.
package battleship_pkg;

  typedef enum logic [1:0] {
    IDLE,
    VALIDATE,
    PROBE,
    FINISH
  } state_e;

  localparam logic [3:0] BOARD_MIN = 4'd1;
  localparam logic [3:0] BOARD_MAX = 4'd10;

  localparam logic [4:0] SHIP_PATROL     = 5'b00001;
  localparam logic [4:0] SHIP_DESTROYER  = 5'b00010;
  localparam logic [4:0] SHIP_SUBMARINE  = 5'b00100;
  localparam logic [4:0] SHIP_BATTLESHIP = 5'b01000;
  localparam logic [4:0] SHIP_CARRIER    = 5'b10000;

  localparam int unsigned BIG_STEPS = 5;

  // 5-bit two's-complement offsets: centre, up, down, left, right
  localparam logic [4:0] STEP_DX [BIG_STEPS] = '{5'd0, 5'd0, 5'd0, 5'h1f, 5'd1};
  localparam logic [4:0] STEP_DY [BIG_STEPS] = '{5'd0, 5'h1f, 5'd1, 5'd0, 5'd0};

  function automatic logic on_board(input logic [4:0] c);
    return (c >= {1'b0, BOARD_MIN}) && (c <= {1'b0, BOARD_MAX});
  endfunction

  function automatic logic [4:0] top_onehot(input logic [4:0] v);
    logic [4:0] r;
    r = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (v[i]) r = 5'b00001 << i;
    end
    return r;
  endfunction

endpackage

// File: rtl/shot_sequencer_key_edge_detect.sv
// Two-flop synchroniser for the raw active-low key plus a falling-edge detector
// that yields a single-cycle press pulse per key press.
module key_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic press_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= key_ni;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign press_o = prev_q & ~sync_q;

endmodule

// File: rtl/shot_sequencer.sv
// Battleship shot sequencer: validates a key press, probes one or five squares
// through the external checker and registers the combined shot result.
// Optional build macro: SHOT_SEQ_REPEAT_CHECK_EN (reject repeated centre squares).
module shot_sequencer
  import battleship_pkg::*;
#(
  parameter int unsigned BIG_BOMBS = 2,
  parameter int unsigned HIT_SAT   = 9
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       key_L,
  input  logic [3:0] x_in,
  input  logic [3:0] y_in,
  input  logic       big_in,
  output logic [3:0] probe_x,
  output logic [3:0] probe_y,
  output logic       probe_valid,
  input  logic       chk_hit,
  input  logic       chk_near,
  input  logic [4:0] chk_ship,
  output logic       hit,
  output logic       near_miss,
  output logic       miss,
  output logic [4:0] biggest_ship_hit,
  output logic [3:0] num_hits,
  output logic [1:0] big_left,
  output logic       something_wrong,
  output logic       busy,
  output logic       done
);

  state_e     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [3:0] cx_q, cx_d, cy_q, cy_d;
  logic       big_q, big_d;
  logic       acc_hit_q, acc_hit_d, acc_near_q, acc_near_d;
  logic [4:0] acc_ship_q, acc_ship_d;
  logic       hit_q, hit_d, near_q, near_d, miss_q, miss_d;
  logic [4:0] ship_q, ship_d;
  logic [3:0] num_hits_q, num_hits_d;
  logic [1:0] big_left_q, big_left_d;
  logic       wrong_q, wrong_d, done_q, done_d;

  logic       shot_start, press_wrong, in_probe;
  logic [4:0] px5, py5;
  logic [2:0] last_step;

  key_edge_detect u_key_edge (
    .clk_i  (clock),
    .rst_ni (reset_L),
    .key_ni (key_L),
    .press_o(shot_start)
  );

  assign in_probe    = (state_q == PROBE);
  assign px5         = {1'b0, cx_q} + STEP_DX[step_q];
  assign py5         = {1'b0, cy_q} + STEP_DY[step_q];
  assign probe_valid = in_probe && on_board(px5) && on_board(py5);
  assign probe_x     = in_probe ? px5[3:0] : '0;
  assign probe_y     = in_probe ? py5[3:0] : '0;
  assign last_step   = big_q ? 3'(BIG_STEPS - 1) : 3'd0;

`ifdef SHOT_SEQ_REPEAT_CHECK_EN
  logic [99:0] fired_q, fired_d;
  logic [6:0]  cell_idx;

  assign cell_idx = 7'(cy_q - 4'd1) * 7'd10 + 7'(cx_q - 4'd1);

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) fired_q <= '0;
    else          fired_q <= fired_d;
  end
`endif

  always_comb begin
    press_wrong = !on_board({1'b0, cx_q}) || !on_board({1'b0, cy_q}) ||
                  (big_q && (big_left_q == '0));
`ifdef SHOT_SEQ_REPEAT_CHECK_EN
    // index only meaningful once the centre is known to be on the board
    if (!press_wrong && fired_q[cell_idx]) press_wrong = 1'b1;
`endif
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    big_d      = big_q;
    acc_hit_d  = acc_hit_q;
    acc_near_d = acc_near_q;
    acc_ship_d = acc_ship_q;
    hit_d      = hit_q;
    near_d     = near_q;
    miss_d     = miss_q;
    ship_d     = ship_q;
    num_hits_d = num_hits_q;
    big_left_d = big_left_q;
    wrong_d    = wrong_q;
    done_d     = 1'b0;
`ifdef SHOT_SEQ_REPEAT_CHECK_EN
    fired_d    = fired_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (shot_start) begin
          cx_d    = x_in;
          cy_d    = y_in;
          big_d   = big_in;
          state_d = VALIDATE;
        end
      end
      VALIDATE: begin
        if (press_wrong) begin
          wrong_d = 1'b1;
          state_d = IDLE;
        end else begin
          wrong_d    = 1'b0;
          acc_hit_d  = 1'b0;
          acc_near_d = 1'b0;
          acc_ship_d = '0;
          step_d     = '0;
          state_d    = PROBE;
        end
      end
      PROBE: begin
        if (probe_valid) begin
          acc_hit_d  = acc_hit_q | chk_hit;
          acc_near_d = acc_near_q | chk_near;
          acc_ship_d = acc_ship_q | chk_ship;
        end
        if (step_q == last_step) state_d = FINISH;
        else                     step_d  = step_q + 3'd1;
      end
      FINISH: begin
        hit_d  = acc_hit_q;
        near_d = !acc_hit_q && acc_near_q;
        miss_d = !acc_hit_q && !acc_near_q;
        ship_d = top_onehot(acc_ship_q);
        if (acc_hit_q && (num_hits_q < 4'(HIT_SAT))) num_hits_d = num_hits_q + 4'd1;
        if (big_q) big_left_d = big_left_q - 2'd1;
`ifdef SHOT_SEQ_REPEAT_CHECK_EN
        fired_d[cell_idx] = 1'b1;
`endif
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= IDLE;
      step_q     <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      big_q      <= 1'b0;
      acc_hit_q  <= 1'b0;
      acc_near_q <= 1'b0;
      acc_ship_q <= '0;
      hit_q      <= 1'b0;
      near_q     <= 1'b0;
      miss_q     <= 1'b0;
      ship_q     <= '0;
      num_hits_q <= '0;
      big_left_q <= 2'(BIG_BOMBS);
      wrong_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      big_q      <= big_d;
      acc_hit_q  <= acc_hit_d;
      acc_near_q <= acc_near_d;
      acc_ship_q <= acc_ship_d;
      hit_q      <= hit_d;
      near_q     <= near_d;
      miss_q     <= miss_d;
      ship_q     <= ship_d;
      num_hits_q <= num_hits_d;
      big_left_q <= big_left_d;
      wrong_q    <= wrong_d;
      done_q     <= done_d;
    end
  end

  assign hit              = hit_q;
  assign near_miss        = near_q;
  assign miss             = miss_q;
  assign biggest_ship_hit = ship_q;
  assign num_hits         = num_hits_q;
  assign big_left         = big_left_q;
  assign something_wrong  = wrong_q;
  assign busy             = (state_q != IDLE);
  assign done             = done_q;

endmodule

// File: tb/tb_shot_sequencer.sv
// Scoreboard bench for shot_sequencer: a board-level model predicts probes and
// shot results, a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_shot_sequencer;
  import battleship_pkg::*;

  logic       clock = 1'b0, reset_L = 1'b0, key_L = 1'b1;
  logic [3:0] x_in = '0, y_in = '0;
  logic       big_in = 1'b0;
  logic [3:0] probe_x, probe_y;
  logic       probe_valid;
  logic       chk_hit, chk_near;
  logic [4:0] chk_ship;
  logic       hit, near_miss, miss, something_wrong, busy, done;
  logic [4:0] biggest_ship_hit;
  logic [3:0] num_hits;
  logic [1:0] big_left;

  shot_sequencer #(.BIG_BOMBS(2), .HIT_SAT(9)) dut (
    .clock(clock), .reset_L(reset_L), .key_L(key_L),
    .x_in(x_in), .y_in(y_in), .big_in(big_in),
    .probe_x(probe_x), .probe_y(probe_y), .probe_valid(probe_valid),
    .chk_hit(chk_hit), .chk_near(chk_near), .chk_ship(chk_ship),
    .hit(hit), .near_miss(near_miss), .miss(miss),
    .biggest_ship_hit(biggest_ship_hit), .num_hits(num_hits), .big_left(big_left),
    .something_wrong(something_wrong), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- board and checker responder ----------------
  logic [4:0] board [0:11][0:11];

  function automatic logic [4:0] ship_at(int x, int y);
    if (x < 1 || x > 10 || y < 1 || y > 10) return '0;
    return board[x][y];
  endfunction

  function automatic bit near_at(int x, int y);
    return (ship_at(x, y) == 0) &&
           (ship_at(x-1, y) != 0 || ship_at(x+1, y) != 0 ||
            ship_at(x, y-1) != 0 || ship_at(x, y+1) != 0);
  endfunction

  // Off-board or idle cycles get a garbage "everything hit" reply that must be ignored.
  always_comb begin
    if (probe_valid) begin
      chk_ship = ship_at(int'(probe_x), int'(probe_y));
      chk_hit  = (chk_ship != 5'd0);
      chk_near = near_at(int'(probe_x), int'(probe_y));
    end else begin
      chk_ship = '1;
      chk_hit  = 1'b1;
      chk_near = 1'b1;
    end
  end

  // ---------------- checking ----------------
  int unsigned n_checks = 0, n_errors = 0;

  task automatic check(string name, int unsigned act, int unsigned req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  typedef struct {
    int unsigned cyc;
    bit          rejected;
    bit          hit, nearm, miss;
    logic [4:0]  ship;
    int unsigned nh, bl;
  } exp_t;

  typedef struct {
    int unsigned cyc;
    int unsigned x, y;
  } probe_t;

  exp_t   exp_q[$];
  probe_t probe_q[$];

  // ---------------- reference model ----------------
  int unsigned m_hits, m_big;
  bit          m_hit, m_near, m_miss;
  logic [4:0]  m_ship;
  bit          fired [1:10][1:10];

  function automatic void model_reset();
    m_hits = 0; m_big = 2; m_hit = 0; m_near = 0; m_miss = 0; m_ship = '0;
    foreach (fired[i, j]) fired[i][j] = 0;
  endfunction

  function automatic void model_shot(int x, int y, bit big, int unsigned c);
    int   dx[5] = '{0, 0, 0, -1, 1};
    int   dy[5] = '{0, -1, 1, 0, 0};
    int   nsq;
    bit   wrong, h, n;
    logic [4:0] s;
    exp_t e;
    probe_t p;
    wrong = (x < 1 || x > 10 || y < 1 || y > 10 || (big && m_big == 0));
`ifdef SHOT_SEQ_REPEAT_CHECK_EN
    if (!wrong && fired[x][y]) wrong = 1;
`endif
    if (wrong) begin
      e.cyc = c + 4; e.rejected = 1;
    end else begin
      nsq = big ? 5 : 1;
      h = 0; n = 0; s = '0;
      for (int i = 0; i < nsq; i++) begin
        int px = x + dx[i], py = y + dy[i];
        if (px >= 1 && px <= 10 && py >= 1 && py <= 10) begin
          p.cyc = c + 4 + i; p.x = px; p.y = py;
          probe_q.push_back(p);
          s |= ship_at(px, py);
          if (ship_at(px, py) != 0) h = 1;
          if (near_at(px, py)) n = 1;
        end
      end
      m_hit = h; m_near = !h && n; m_miss = !h && !n;
      m_ship = '0;
      for (int b = 4; b >= 0; b--) if (s[b] && m_ship == 0) m_ship = 5'd1 << b;
      if (h && m_hits < 9) m_hits++;
      if (big) m_big--;
`ifdef SHOT_SEQ_REPEAT_CHECK_EN
      fired[x][y] = 1;
`endif
      e.cyc = c + (big ? 10 : 6); e.rejected = 0;
    end
    e.hit = m_hit; e.nearm = m_near; e.miss = m_miss; e.ship = m_ship;
    e.nh = m_hits; e.bl = m_big;
    exp_q.push_back(e);
  endfunction

  // ---------------- monitor ----------------
  bit mon_en = 0;

  always @(negedge clock) begin : monitor
    exp_t   e;
    probe_t p;
    if (mon_en) begin
      if (probe_valid) begin
        if (probe_q.size() == 0) check("unexpected_probe", 1, 0);
        else begin
          p = probe_q.pop_front();
          check("probe_cycle", cyc, p.cyc);
          check("probe_x", probe_x, p.x);
          check("probe_y", probe_y, p.y);
        end
      end
      if (!busy) begin
        check("idle_probe", {probe_valid, probe_x, probe_y}, 0);
      end
      if (done) begin
        if (exp_q.size() == 0 || exp_q[0].rejected) check("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("hit", hit, e.hit);
          check("near_miss", near_miss, e.nearm);
          check("miss", miss, e.miss);
          check("biggest_ship_hit", biggest_ship_hit, e.ship);
          check("num_hits", num_hits, e.nh);
          check("big_left", big_left, e.bl);
          check("wrong_cleared", something_wrong, 0);
        end
      end else if (exp_q.size() != 0) begin
        if (exp_q[0].rejected && cyc == exp_q[0].cyc) begin
          e = exp_q.pop_front();
          check("something_wrong", something_wrong, 1);
          check("rej_hit", hit, e.hit);
          check("rej_near_miss", near_miss, e.nearm);
          check("rej_miss", miss, e.miss);
          check("rej_big_left", big_left, e.bl);
          check("rej_num_hits", num_hits, e.nh);
        end else if (!exp_q[0].rejected && cyc > exp_q[0].cyc) begin
          e = exp_q.pop_front();
          check("done_timeout", 0, 1);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic shoot(int x, int y, bit big, int hold);
    int unsigned c;
    @(negedge clock);
    x_in = 4'(x); y_in = 4'(y); big_in = big;
    key_L = 1'b0;
    c = cyc;
    model_shot(x, y, big, c);
    repeat (hold) @(negedge clock);
    key_L = 1'b1;
    repeat (4) @(negedge clock);
    while (cyc < c + 14) @(negedge clock);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_hit"}, hit, 0);
    check({tag, "_near"}, near_miss, 0);
    check({tag, "_miss"}, miss, 0);
    check({tag, "_ship"}, biggest_ship_hit, 0);
    check({tag, "_num_hits"}, num_hits, 0);
    check({tag, "_big_left"}, big_left, 2);
    check({tag, "_wrong"}, something_wrong, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_probe"}, {probe_valid, probe_x, probe_y}, 0);
  endtask

  initial begin
    int unsigned c;
    foreach (board[i, j]) board[i][j] = '0;
    board[7][6] = SHIP_PATROL;     board[7][7] = SHIP_PATROL;
    for (int i = 3; i <= 7; i++) board[i][1] = SHIP_CARRIER;
    board[3][3] = SHIP_DESTROYER;  board[4][3] = SHIP_DESTROYER;
    board[1][2] = SHIP_SUBMARINE;  board[1][3] = SHIP_SUBMARINE;
    for (int j = 7; j <= 10; j++) board[10][j] = SHIP_BATTLESHIP;
    model_reset();

    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset_L = 1'b1;
    repeat (2) @(negedge clock);
    mon_en = 1;

    shoot(7, 6, 0, 3);     // patrol hit
    shoot(7, 5, 0, 2);     // near
    shoot(6, 8, 0, 2);     // miss
    shoot(3, 2, 1, 2);     // big: carrier + destroyer
    shoot(1, 1, 1, 2);     // big at corner, two off-board steps
    shoot(0, 5, 0, 2);     // rejected X=0
    shoot(11, 5, 0, 2);    // rejected X=11
    shoot(5, 5, 1, 2);     // rejected: no big bombs left
    shoot(6, 8, 0, 2);     // valid press clears the error
    shoot(7, 7, 0, 20);    // long hold: one shot only

    // asynchronous reset in the PROBE cycle of a shot
    mon_en = 0;
    @(negedge clock);
    x_in = 4'd7; y_in = 4'd6; big_in = 1'b0; key_L = 1'b0;
    c = cyc;
    while (cyc < c + 4) @(negedge clock);
    check("rst_in_probe", probe_valid, 1);
    #2 reset_L = 1'b0;
    #1 check_reset_outputs("async_reset");
    key_L = 1'b1;
    @(negedge clock);
    reset_L = 1'b1;
    exp_q.delete(); probe_q.delete();
    model_reset();
    repeat (4) @(negedge clock);
    check("post_reset_idle", busy, 0);
    mon_en = 1;

    for (int i = 0; i < 11; i++) shoot(7, 6, 0, 2);   // saturation at 9
    check("saturated", num_hits, 9);

    for (int i = 0; i < 40; i++) begin
      shoot(int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
            ($urandom_range(0, 3) == 0), int'($urandom_range(2, 6)));
    end

    c = cyc;
    while (exp_q.size() != 0 && cyc < c + 100) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    check("probes_drained", probe_q.size(), 0);
    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
